// File: rtl/pack_frame_tx.sv
// Trace word packer: buffers trace words in a FIFO and emits framed bytes
// (sync, sequence, payload LSB-first, XOR checksum) over a ready/next handshake.
module pack_frame_tx #(
  parameter int         WORD_WIDTH  = 16,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         FRAME_WORDS = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync,
  input  logic                        wd_avail,
  input  logic [WORD_WIDTH-1:0]       packet_wd,
  input  logic                        packet_reset,
  output logic                        data_ready,
  output logic [7:0]                  data_val,
  input  logic                        data_next,
  output logic                        data_overf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BPW = WORD_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, HDR, SEQ, DATA, CSUM
  } state_t;

  state_t state, stateNext;

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [LW-1:0] level, levelNext;
  logic [LW-1:0] wordCnt, wordCntNext;
  logic [1:0]    byteIdx, byteIdxNext;
  logic [6:0]    seq;
  logic [7:0]    csum, seqByte, headByte;
  logic          overf;
  logic          xfer, lastByte, full;
  logic          tryPush, push, pop, drop;
  logic [WORD_WIDTH-1:0] headWord;

  assign xfer     = data_ready & data_next;
  assign lastByte = byteIdx == 2'(BPW - 1);
  assign pop      = (state == DATA) & xfer & lastByte & ~packet_reset;
  assign full     = level == LW'(FIFO_DEPTH);
  assign tryPush  = wd_avail & sync & ~packet_reset;
  assign push     = tryPush & (~full | pop);
  assign drop     = tryPush & full & ~pop;

  assign levelNext = packet_reset ? '0
                   : level + LW'(push) - LW'(pop);

  assign headWord = mem[rdPtr];
  assign headByte = 8'(headWord >> {byteIdx, 3'b000});

  assign fifo_level = level;
  assign data_overf = overf;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= packet_wd;
  end

  always_comb begin
    stateNext   = state;
    byteIdxNext = byteIdx;
    wordCntNext = wordCnt;
    data_ready  = state != IDLE;
    data_val    = '0;
    unique case (state)
      IDLE: if (level >= LW'(FRAME_WORDS)) stateNext = HDR;
      HDR: begin
        data_val = SYNC_BYTE;
        if (xfer) stateNext = SEQ;
      end
      SEQ: begin
        data_val = seqByte;
        if (xfer) begin
          stateNext   = DATA;
          byteIdxNext = '0;
          wordCntNext = '0;
        end
      end
      DATA: begin
        data_val = headByte;
        if (xfer) begin
          if (lastByte) begin
            byteIdxNext = '0;
            if (wordCnt == LW'(FRAME_WORDS - 1))
              stateNext = CSUM;
            else
              wordCntNext = wordCnt + 1'b1;
          end else begin
            byteIdxNext = byteIdx + 1'b1;
          end
        end
      end
      CSUM: begin
        data_val = csum;
        if (xfer)
          stateNext = (levelNext >= LW'(FRAME_WORDS))
                    ? HDR : IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (packet_reset) begin
      stateNext   = IDLE;
      byteIdxNext = '0;
      wordCntNext = '0;
    end
  end

  // SEQ byte is latched on entry so a late drop cannot disturb a held byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wrPtr   <= '0;
      rdPtr   <= '0;
      level   <= '0;
      byteIdx <= '0;
      wordCnt <= '0;
      seq     <= '0;
      csum    <= '0;
      seqByte <= '0;
      overf   <= 1'b0;
    end else begin
      state   <= stateNext;
      level   <= levelNext;
      byteIdx <= byteIdxNext;
      wordCnt <= wordCntNext;
      if (packet_reset) begin
        wrPtr <= '0;
        rdPtr <= '0;
        csum  <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
        if (state == DATA && xfer)
          csum <= csum ^ headByte;
        else if (state == CSUM && xfer)
          csum <= '0;
        if (state == CSUM && xfer)
          seq <= seq + 1'b1;
        if (state == HDR && xfer)
          seqByte <= {overf | drop, seq};
      end
      if (drop)
        overf <= 1'b1;
      else if (state == SEQ && xfer && !packet_reset)
        overf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pack_frame_tx.sv
// Directed bench for pack_frame_tx (16-bit words, depth 4, 2 words/frame).
// Expected frames are hand-computed byte lists.
module tb_pack_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sync = 1'b1;
  logic        wd_avail = 1'b0;
  logic [15:0] packet_wd = '0;
  logic        packet_reset = 1'b0;
  logic        data_ready;
  logic [7:0]  data_val;
  logic        data_next = 1'b1;
  logic        data_overf;
  logic [2:0]  fifo_level;

  int nChk = 0;
  int nPass = 0;
  logic [7:0]  rx [16];
  int          rxN;
  logic [15:0] patBits = 16'b0110_1001_1100_0101;

  pack_frame_tx #(
    .WORD_WIDTH (16),
    .FIFO_DEPTH (4),
    .FRAME_WORDS(2),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sync        (sync),
    .wd_avail    (wd_avail),
    .packet_wd   (packet_wd),
    .packet_reset(packet_reset),
    .data_ready  (data_ready),
    .data_val    (data_val),
    .data_next   (data_next),
    .data_overf  (data_overf),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nChk++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic wr(input logic [15:0] w);
    wd_avail  = 1'b1;
    packet_wd = w;
    tick();
    wd_avail  = 1'b0;
  endtask

  task automatic collect(input int n, input bit pat);
    int   cyc = 0;
    logic stall = 1'b0;
    logic [7:0] prevVal = '0;
    rxN = 0;
    while (rxN < n && cyc < 200) begin
      if (stall) chk("hold", 32'(data_val), 32'(prevVal));
      if (pat) data_next = patBits[cyc % 16];
      if (data_ready && data_next) begin
        rx[rxN] = data_val;
        rxN++;
      end
      stall   = data_ready && !data_next;
      prevVal = data_val;
      tick();
      cyc++;
    end
    data_next = 1'b1;
    chk("collect_count", 32'(rxN), 32'(n));
  endtask

  task automatic chkFrame(input string tag, input logic [55:0] e);
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s_b%0d", tag, i),
          32'(rx[i]), 32'(e[55-8*i -: 8]));
  endtask

  initial begin
    #3;
    chk("rst_ready", 32'(data_ready), 32'd0);
    chk("rst_val",   32'(data_val),   32'd0);
    chk("rst_overf", 32'(data_overf), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // basic frame and data_ready latency
    wr(16'h1234);
    wr(16'hABCD);
    chk("lat_ready0", 32'(data_ready), 32'd0);
    chk("lat_level",  32'(fifo_level), 32'd2);
    tick();
    chk("lat_ready1", 32'(data_ready), 32'd1);
    collect(7, 1'b0);
    chkFrame("f0", 56'hA5_00_34_12_CD_AB_40);
    chk("f0_idle",  32'(data_ready), 32'd0);
    chk("f0_level", 32'(fifo_level), 32'd0);

    wr(16'h0001);
    wr(16'h0002);
    collect(7, 1'b0);
    chkFrame("f1", 56'hA5_01_01_00_02_00_03);

    // 128 frames: seq runs 2..7F then wraps to 00, 01
    for (int i = 0; i < 128; i++) begin
      wr(16'(i));
      wr(16'(i + 300));
      collect(7, 1'b0);
      chk($sformatf("wrap_seq%0d", i),
          32'(rx[1]), 32'((i + 2) % 128));
    end

    // overflow while the sink stalls; seq is now 2
    data_next = 1'b0;
    wr(16'h1111);
    wr(16'h2222);
    wr(16'h3333);
    wr(16'h4444);
    wr(16'h5555);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag",  32'(data_overf), 32'd1);
    chk("ovf_hdr",   32'(data_val),   32'hA5);
    data_next = 1'b1;
    collect(7, 1'b0);
    chkFrame("ovf_f", 56'hA5_82_11_11_22_22_00);
    chk("ovf_clr",   32'(data_overf), 32'd0);
    chk("b2b_level", 32'(fifo_level), 32'd2);
    chk("b2b_ready", 32'(data_ready), 32'd1);
    collect(7, 1'b0);
    chkFrame("b2b_f", 56'hA5_03_33_33_44_44_00);
    chk("b2b_level0", 32'(fifo_level), 32'd0);

    // sink toggles data_next; seq 4
    wr(16'h1234);
    wr(16'hABCD);
    collect(7, 1'b1);
    chkFrame("tog_f", 56'hA5_04_34_12_CD_AB_40);

    // abort after third byte; seq 5 reused
    wr(16'hBEEF);
    wr(16'hCAFE);
    collect(3, 1'b0);
    packet_reset = 1'b1;
    tick();
    packet_reset = 1'b0;
    chk("abort_ready", 32'(data_ready), 32'd0);
    chk("abort_level", 32'(fifo_level), 32'd0);
    wr(16'h0001);
    wr(16'h0002);
    collect(7, 1'b0);
    chkFrame("abort_f", 56'hA5_05_01_00_02_00_03);

    // writes out of sync are discarded silently
    sync = 1'b0;
    wr(16'h7777);
    wr(16'h8888);
    wr(16'h9999);
    tick();
    sync = 1'b1;
    chk("nosync_level", 32'(fifo_level), 32'd0);
    chk("nosync_overf", 32'(data_overf), 32'd0);
    chk("nosync_ready", 32'(data_ready), 32'd0);

    // async reset mid-frame with overflow flag set
    data_next = 1'b0;
    wr(16'h1111);
    wr(16'h2222);
    wr(16'h3333);
    wr(16'h4444);
    wr(16'h5555);
    chk("pre_rst_overf", 32'(data_overf), 32'd1);
    chk("pre_rst_ready", 32'(data_ready), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", 32'(data_ready), 32'd0);
    chk("arst_val",   32'(data_val),   32'd0);
    chk("arst_overf", 32'(data_overf), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    rst = 1'b1;
    data_next = 1'b1;
    tick();
    wr(16'h1234);
    wr(16'hABCD);
    collect(7, 1'b0);
    chkFrame("post_rst_f", 56'hA5_00_34_12_CD_AB_40);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
